multicycle_control: RTL

Main control FSM for the multicycle CPU datapath. It sequences instruction fetch, decode, execute, memory access and write-back across shared ALU, memory and register-file resources. It drives the 2-bit `alu_op` consumed by the ALU control decoder (00 = decode funct field, 01 = subtract, 10 = add, 11 = ALU function 6). It stalls on a memory ready handshake and counts retired instructions.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle CPU main controller.
// master = controller side, slave = datapath side.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op,
               instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op,
               instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: sequences fetch/decode/execute/memory/write-back,
// stalls on the memory ready handshake and counts retired instructions.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input logic                   clk,
    input logic                   rst,
    multicycle_control_if.master  ctrl_if
);
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAluF6 = 6'h0C;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StRwb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIwb     = 4'd11,
        StIllegal = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch:   state_d = ctrl_if.mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (ctrl_if.opcode)
                    OpRtype:         state_d = StExec;
                    OpLw, OpSw:      state_d = StMemAdr;
                    OpBeq:           state_d = StBranch;
                    OpJ:             state_d = StJump;
                    OpAddi, OpAluF6: state_d = StIExec;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr:  state_d = (ctrl_if.opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = ctrl_if.mem_ready ? StMemWb : StMemRd;
            StMemWr:   state_d = ctrl_if.mem_ready ? StFetch : StMemWr;
            StExec:    state_d = StRwb;
            StIExec:   state_d = StIwb;
            default:   state_d = StFetch;
        endcase
    end

    // An instruction retires on leaving its final state; a stalled store has not finished.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            StMemWb, StRwb, StBranch, StJump, StIwb: retire = 1'b1;
            StMemWr:                                 retire = ctrl_if.mem_ready;
            default:                                 retire = 1'b0;
        endcase
        count_d = retire ? count_q + 1'b1 : count_q;
    end

    always_comb begin
        ctrl_if.pc_write   = 1'b0;
        ctrl_if.iord       = 1'b0;
        ctrl_if.mem_read   = 1'b0;
        ctrl_if.mem_write  = 1'b0;
        ctrl_if.ir_write   = 1'b0;
        ctrl_if.reg_dst    = 1'b0;
        ctrl_if.mem_to_reg = 1'b0;
        ctrl_if.reg_write  = 1'b0;
        ctrl_if.alu_src_a  = 1'b0;
        ctrl_if.alu_src_b  = 2'b00;
        ctrl_if.alu_op     = 2'b00;
        ctrl_if.pc_source  = 2'b00;
        ctrl_if.illegal_op = 1'b0;
        // Reset masks every strobe so an abandoned instruction cannot write anything.
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    ctrl_if.mem_read  = 1'b1;
                    ctrl_if.alu_src_b = 2'b01;
                    ctrl_if.alu_op    = 2'b10;
                    ctrl_if.ir_write  = ctrl_if.mem_ready;
                    ctrl_if.pc_write  = ctrl_if.mem_ready;
                end
                StDecode: begin
                    ctrl_if.alu_src_b = 2'b11;
                    ctrl_if.alu_op    = 2'b10;
                end
                StMemAdr: begin
                    ctrl_if.alu_src_a = 1'b1;
                    ctrl_if.alu_src_b = 2'b10;
                    ctrl_if.alu_op    = 2'b10;
                end
                StMemRd: begin
                    ctrl_if.mem_read = 1'b1;
                    ctrl_if.iord     = 1'b1;
                end
                StMemWb: begin
                    ctrl_if.reg_write  = 1'b1;
                    ctrl_if.mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    ctrl_if.mem_write = 1'b1;
                    ctrl_if.iord      = 1'b1;
                end
                StExec: begin
                    ctrl_if.alu_src_a = 1'b1;
                end
                StRwb: begin
                    ctrl_if.reg_write = 1'b1;
                    ctrl_if.reg_dst   = 1'b1;
                end
                StBranch: begin
                    ctrl_if.alu_src_a = 1'b1;
                    ctrl_if.alu_op    = 2'b01;
                    ctrl_if.pc_source = 2'b01;
                    ctrl_if.pc_write  = ctrl_if.zero;
                end
                StJump: begin
                    ctrl_if.pc_source = 2'b10;
                    ctrl_if.pc_write  = 1'b1;
                end
                StIExec: begin
                    ctrl_if.alu_src_a = 1'b1;
                    ctrl_if.alu_src_b = 2'b10;
                    ctrl_if.alu_op    = (ctrl_if.opcode == OpAluF6) ? 2'b11 : 2'b10;
                end
                StIwb: begin
                    ctrl_if.reg_write = 1'b1;
                end
                StIllegal: begin
                    ctrl_if.illegal_op = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ctrl_if.state       = rst ? 4'd0 : state_q;
    assign ctrl_if.instr_count = count_q;
endmodule
